// File: rtl/link_arb_pkg.sv
// Shared types and constants for the round-robin link arbiter.
// The optional LINK_ARB_LOCK_EN feature is handled in link_rr_arbiter.sv.
package link_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 8;

  // Width of a requester index; never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester at or after start
// (wrapping modulo N) whose req bit is set and exclude bit is clear.
module rr_pick
  import link_arb_pkg::*;
#(
  parameter int N  = N_REQ_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic          found,
  output logic [IW-1:0] winner
);

  int            idx;
  logic [IW-1:0] pos;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    pos    = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(start) + k) % N;
      pos = idx[IW-1:0];
      if (!found && req[pos] && !excl[pos]) begin
        found  = 1'b1;
        winner = pos;
      end
    end
  end

endmodule

// File: rtl/link_rr_arbiter.sv
// Round-robin owner of a shared passthrough link with bounded tenures.
// Define LINK_ARB_LOCK_EN to add a lock input that suspends the hold timeout.
module link_rr_arbiter
  import link_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
`ifdef LINK_ARB_LOCK_EN
  input  logic                      lock,
`endif
  output logic [N_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]         link_out,
  output logic                      link_valid,
  output logic [idx_w(N_REQ)-1:0]   owner
);

  localparam int IW = idx_w(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);

  // Handshake: req[i] is a level request; gnt[i] is the registered answer.
  // A requester keeps req high while it wants the link and drops it when
  // done; the grant follows one edge later in both directions.

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [HW-1:0]      hold_q, hold_d;

  logic [IW-1:0]      start;
  logic [N_REQ-1:0]   excl;
  logic               found;
  logic [IW-1:0]      winner;
  logic               own_req;
  logic               locked;
  logic               tenure_end;

  assign own_req = req[owner_q];
  assign start   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  // A still-requesting owner stays eligible, but is reached last in the scan.
  always_comb begin
    excl = '0;
    if (state_q == GRANT && !own_req) excl[owner_q] = 1'b1;
  end

`ifdef LINK_ARB_LOCK_EN
  assign locked = lock & own_req;
`else
  assign locked = 1'b0;
`endif

  assign tenure_end = !own_req || (hold_q == HOLD_LAST && !locked);

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req),
    .start  (start),
    .excl   (excl),
    .found  (found),
    .winner (winner)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d         = GRANT;
          gnt_d           = '0;
          gnt_d[winner]   = 1'b1;
          owner_d         = winner;
          hold_d          = '0;
        end
      end
      GRANT: begin
        if (tenure_end) begin
          hold_d = '0;
          gnt_d  = '0;
          if (found) begin
            gnt_d[winner] = 1'b1;
            owner_d       = winner;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= LAST_IDX;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    link_out = '0;
    for (int i = 0; i < N_REQ; i++) begin
      link_out = link_out | (data_in[i*DATA_W +: DATA_W] & {DATA_W{gnt_q[i]}});
    end
  end

  assign gnt        = gnt_q;
  assign link_valid = |gnt_q;
  assign owner      = owner_q;

endmodule
